// File: rtl/addsub_rr_scheduler.sv
// Round-robin scheduler that shares one signed add/sub unit between NREQ requesters.
// Each result returns on a single response channel, tagged with the requester index.
module addsub_rr_scheduler #(
  parameter int unsigned n    = 4,
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*n-1:0] req_a,
  input  logic [NREQ*n-1:0] req_b,
  input  logic [NREQ-1:0]   req_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [n:0]        rsp_ans,
  output logic              busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [n-1:0]   a_q, a_d, b_q, b_d;
  logic           sel_q, sel_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [n:0]     rsp_ans_q, rsp_ans_d;
  logic [n:0]     ans;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;

  // Search starts just after the last grant, so the previous winner is checked last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (!grant_found && req_valid[(int'(last_grant_q) + k) % int'(NREQ)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((int'(last_grant_q) + k) % int'(NREQ));
      end
    end
  end

  // Sign-extend before the operation so the n+1 bit result never wraps.
  always_comb begin
    if (sel_q) ans = {a_q[n-1], a_q} + {b_q[n-1], b_q};
    else       ans = {a_q[n-1], a_q} - {b_q[n-1], b_q};
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == StIdle && grant_found) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gid_d        = gid_q;
    a_d          = a_q;
    b_d          = b_q;
    sel_d        = sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_ans_d    = rsp_ans_q;
    case (state_q)
      StIdle: begin
        if (grant_found) begin
          a_d          = req_a[grant_idx*n +: n];
          b_d          = req_b[grant_idx*n +: n];
          sel_d        = req_sel[grant_idx];
          gid_d        = grant_idx;
          last_grant_d = grant_idx;
          state_d      = StExec;
        end
      end
      StExec: begin
        rsp_ans_d   = ans;
        rsp_id_d    = gid_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= IDW'(NREQ - 1);
      gid_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_ans_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gid_q        <= gid_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sel_q        <= sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_ans_q    <= rsp_ans_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_ans   = rsp_ans_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Directed bench for addsub_rr_scheduler: single ops, width extremes, fairness,
// backpressure, reset mid-operation and request withdrawal.
module tb_addsub_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [4:0]  rsp_ans;
  logic        busy;

  int n_checks = 0;
  int n_bad    = 0;

  addsub_rr_scheduler #(.n(4), .NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_ans   (rsp_ans),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation from requester id; expects the response after two edges.
  task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b,
                       input logic sel, input logic [4:0] exp_ans);
    req_a[id*4 +: 4] = a;
    req_b[id*4 +: 4] = b;
    req_sel[id]      = sel;
    req_valid        = 4'b0001 << id;
    #1;
    check_eq("op_ready", 32'(req_ready), 32'(4'b0001 << id));
    tick();
    req_valid = 4'b0000;
    check_eq("op_exec_valid", 32'(rsp_valid), 32'd0);
    tick();
    check_eq("op_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("op_rsp_id", 32'(rsp_id), 32'(id));
    check_eq("op_rsp_ans", 32'(rsp_ans), 32'(exp_ans));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("op_back_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
    do_reset();

    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("rst_rsp_ans", 32'(rsp_ans), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);

    // Single op: 3 - 5 = -2
    do_op(2, 4'd3, 4'd5, 1'b0, 5'b11110);

    // Width extremes
    do_op(0, 4'h7, 4'h7, 1'b1, 5'b01110);
    do_op(1, 4'h8, 4'h8, 1'b1, 5'b10000);
    do_op(2, 4'h8, 4'h7, 1'b0, 5'b10001);
    do_op(3, 4'h7, 4'h8, 1'b0, 5'b01111);

    // Fairness: all valid, grants rotate starting at 0, one response per 3 cycles
    do_reset();
    req_a     = 16'h3210;
    req_b     = 16'h1111;
    req_sel   = 4'b1111;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_eq("fair_ready", 32'(req_ready), 32'(4'b0001 << (i % 4)));
      tick();
      check_eq("fair_exec_ready", 32'(req_ready), 32'd0);
      tick();
      check_eq("fair_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("fair_rsp_id", 32'(rsp_id), 32'(i % 4));
      check_eq("fair_rsp_ans", 32'(rsp_ans), 32'((i % 4) + 1));
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b0;

    // Backpressure: last grant was 1, only requester 3 asks; 2 + 1 = 3
    req_a[12 +: 4] = 4'd2;
    req_b[12 +: 4] = 4'd1;
    req_sel[3]     = 1'b1;
    req_valid      = 4'b1000;
    #1;
    check_eq("bp_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0001;
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_rsp_id", 32'(rsp_id), 32'd3);
      check_eq("bp_rsp_ans", 32'(rsp_ans), 32'd3);
      check_eq("bp_req_ready", 32'(req_ready), 32'd0);
      check_eq("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("bp_release_valid", 32'(rsp_valid), 32'd0);
    check_eq("bp_release_busy", 32'(busy), 32'd0);

    // Reset in EXEC drops the op and restores requester 0 priority
    req_valid = 4'b0100;
    tick();
    check_eq("rmid_in_exec", 32'(busy), 32'd1);
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    tick();
    check_eq("rmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rmid_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("rmid_rsp_ans", 32'(rsp_ans), 32'd0);
    check_eq("rmid_busy", 32'(busy), 32'd0);
    check_eq("rmid_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rmid_first_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    check_eq("rmid_rsp_id0", 32'(rsp_id), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Withdrawal: requester 1 pulses valid only while the block is in RESP
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    req_valid = 4'b0010;
    #1;
    check_eq("wd_ready_resp", 32'(req_ready), 32'd0);
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("wd_no_rsp", 32'(rsp_valid), 32'd0);
      check_eq("wd_idle", 32'(busy), 32'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
